riscv_pu_pipeline_ctrl: RTL and testbench

Pipeline sequencing controller for the RISC-V core. It generates the per-stage register enables and flushes for IF/ID/EX/MEM/WB, and schedules three kinds of event: load-use bubbles the EX forwarding network cannot cover, control-flow redirects, and multi-cycle data-memory accesses on the AXI-lite path. It also detects memory timeouts and errors, holds the core in a halt state on a fault, and exports saturating stall and flush performance counters.

---
 rtl/riscv_pkg.sv | 28 ++
 rtl/riscv_pu_sat_counter.sv | 29 ++
 rtl/riscv_pu_pipeline_ctrl.sv | 172 +++++++++++++++++
 tb/tb_riscv_pu_pipeline_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and helpers for the RISC-V pipeline controller.
//   pu_ctrl_state_e     : sequencing FSM states (RUN / MEM_WAIT / HALT)
//   PU_MEM_TIMEOUT_DEF  : default MEM_WAIT timeout in cycles
//   pu_load_use()       : load-use hazard detect between ID sources and the EX load
package riscv_pkg;

  typedef enum logic [1:0] {
    PU_RUN      = 2'b00,
    PU_MEM_WAIT = 2'b01,
    PU_HALT     = 2'b10
  } pu_ctrl_state_e;

  localparam int unsigned PU_MEM_TIMEOUT_DEF = 256;

  // A load in EX whose result an ID source needs next cycle; x0 never hazards.
  function automatic logic pu_load_use(
    input logic       ex_mem_read,
    input logic [4:0] ex_rd,
    input logic [4:0] rs1,
    input logic       rs1_used,
    input logic [4:0] rs2,
    input logic       rs2_used
  );
    return ex_mem_read & (ex_rd != 5'd0) &
           ((rs1_used & (rs1 == ex_rd)) | (rs2_used & (rs2 == ex_rd)));
  endfunction

endpackage

// File: rtl/riscv_pu_sat_counter.sv
// Saturating up-counter used for pipeline performance statistics.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   inc            : count one event this cycle
//   clr            : synchronous clear, wins over inc
//   cnt            : current count, sticks at all-ones
module riscv_pu_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  // Count register: clear has priority, increment stops at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {WIDTH{1'b1}})) begin
      cnt <= cnt + WIDTH'(1);
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/riscv_pu_pipeline_ctrl.sv
// Pipeline sequencing controller: stage enables/flushes for IF/ID/EX/MEM/WB,
// load-use bubbles, redirect flushes, multi-cycle MEM waits with timeout,
// fault HALT and saturating stall/flush counters.
//   i_id_*            : ID-stage source registers and use flags
//   i_ex_*            : EX load flag, destination, redirect
//   i_mem_*           : MEM request, completion, error (error qualified by ready)
//   i_halt_clr        : leave HALT
//   i_cnt_clr         : clear both performance counters
//   o_*_en / o_*_flush: combinational stage controls (forced safe in reset)
//   o_fault, o_state  : registered status
//   o_stall_cnt/o_flush_cnt : performance counters
module riscv_pu_pipeline_ctrl
  import riscv_pkg::*;
#(
  parameter int MEM_TIMEOUT = PU_MEM_TIMEOUT_DEF,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [4:0]           i_id_rs1_addr,
  input  logic [4:0]           i_id_rs2_addr,
  input  logic                 i_id_rs1_used,
  input  logic                 i_id_rs2_used,
  input  logic                 i_ex_mem_read,
  input  logic [4:0]           i_ex_rd_addr,
  input  logic                 i_ex_redirect,
  input  logic                 i_mem_req,
  input  logic                 i_mem_ready,
  input  logic                 i_mem_err,
  input  logic                 i_halt_clr,
  input  logic                 i_cnt_clr,
  output logic                 o_pc_en,
  output logic                 o_if_id_en,
  output logic                 o_id_ex_en,
  output logic                 o_ex_mem_en,
  output logic                 o_mem_wb_en,
  output logic                 o_if_id_flush,
  output logic                 o_id_ex_flush,
  output logic                 o_ex_mem_flush,
  output logic                 o_fault,
  output logic [1:0]           o_state,
  output logic [CNT_WIDTH-1:0] o_stall_cnt,
  output logic [CNT_WIDTH-1:0] o_flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  // Enable vector order: {pc, if_id, id_ex, ex_mem, mem_wb}
  // Flush vector order:  {if_id, id_ex, ex_mem}
  pu_ctrl_state_e    r_state;
  pu_ctrl_state_e    w_next_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_next;
  logic              r_fault;
  logic [4:0]        w_en;
  logic [2:0]        w_fl;
  logic              w_flush_inc;
  logic [4:0]        w_run_en;
  logic [2:0]        w_run_fl;
  logic              w_run_redirect;
  logic              w_load_use;

  assign w_load_use = pu_load_use(i_ex_mem_read, i_ex_rd_addr, i_id_rs1_addr,
                                  i_id_rs1_used, i_id_rs2_addr, i_id_rs2_used);

  // Redirect/load-use/normal controls, shared by RUN and the MEM_WAIT exit cycle.
  always_comb begin
    w_run_en       = 5'b11111;
    w_run_fl       = 3'b000;
    w_run_redirect = 1'b0;
    if (i_ex_redirect) begin
      w_run_en       = 5'b11111;
      w_run_fl       = 3'b110;
      w_run_redirect = 1'b1;
    end else if (w_load_use) begin
      w_run_en = 5'b00111;
      w_run_fl = 3'b010;
    end else begin
      w_run_en = 5'b11111;
      w_run_fl = 3'b000;
    end
  end

  // Next-state, wait counter and stage controls.
  always_comb begin
    w_en         = 5'b00000;
    w_fl         = 3'b000;
    w_flush_inc  = 1'b0;
    w_next_state = r_state;
    w_wait_next  = '0;
    case (r_state)
      PU_RUN: begin
        if (i_mem_req && !i_mem_ready) begin
          w_next_state = PU_MEM_WAIT;
        end else begin
          w_en         = w_run_en;
          w_fl         = w_run_fl;
          w_flush_inc  = w_run_redirect;
          // A zero-wait access that returns an error still faults.
          w_next_state = (i_mem_req && i_mem_err) ? PU_HALT : PU_RUN;
        end
      end
      PU_MEM_WAIT: begin
        if (i_mem_ready && !i_mem_err) begin
          // Pending redirect/load-use is applied on the exit cycle.
          w_en         = w_run_en;
          w_fl         = w_run_fl;
          w_flush_inc  = w_run_redirect;
          w_next_state = PU_RUN;
        end else if (i_mem_ready && i_mem_err) begin
          w_next_state = PU_HALT;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_next_state = PU_HALT;
        end else begin
          w_wait_next = r_wait_cnt + WAIT_W'(1);
        end
      end
      PU_HALT: begin
        if (i_halt_clr) begin
          w_en         = 5'b11111;
          w_fl         = 3'b111;
          w_next_state = PU_RUN;
        end else begin
          w_next_state = PU_HALT;
        end
      end
      default: begin
        w_next_state = PU_RUN;
      end
    endcase
  end

  // State, wait counter and fault flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= PU_RUN;
      r_wait_cnt <= '0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_next;
      r_fault    <= (w_next_state == PU_HALT);
    end
  end

  // In reset every stage is frozen and every bubble inserted.
  assign {o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en} =
         i_rst_n ? w_en : 5'b00000;
  assign {o_if_id_flush, o_id_ex_flush, o_ex_mem_flush} =
         i_rst_n ? w_fl : 3'b111;

  assign o_fault = r_fault;
  assign o_state = r_state;

  riscv_pu_sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .inc     (~w_en[4]),
    .clr     (i_cnt_clr),
    .cnt     (o_stall_cnt)
  );

  riscv_pu_sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .inc     (w_flush_inc),
    .clr     (i_cnt_clr),
    .cnt     (o_flush_cnt)
  );

endmodule

// File: tb/tb_riscv_pu_pipeline_ctrl.sv
// Self-checking bench for riscv_pu_pipeline_ctrl (MEM_TIMEOUT=4, CNT_WIDTH=4).
module tb_riscv_pu_pipeline_ctrl;

  localparam int T    = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    rs1, rs2, rd;
  logic          rs1_used, rs2_used, ex_mem_read, redirect;
  logic          mem_req, mem_ready, mem_err, halt_clr, cnt_clr;
  logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic          if_id_fl, id_ex_fl, ex_mem_fl, fault;
  logic [1:0]    state;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: 0 = running, 1 = waiting on memory, 2 = halted
  int m_state, m_wait, m_stall, m_flush;

  always #5 clk = ~clk;

  riscv_pu_pipeline_ctrl #(.MEM_TIMEOUT(T), .CNT_WIDTH(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2),
    .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used),
    .i_ex_mem_read(ex_mem_read), .i_ex_rd_addr(rd), .i_ex_redirect(redirect),
    .i_mem_req(mem_req), .i_mem_ready(mem_ready), .i_mem_err(mem_err),
    .i_halt_clr(halt_clr), .i_cnt_clr(cnt_clr),
    .o_pc_en(pc_en), .o_if_id_en(if_id_en), .o_id_ex_en(id_ex_en),
    .o_ex_mem_en(ex_mem_en), .o_mem_wb_en(mem_wb_en),
    .o_if_id_flush(if_id_fl), .o_id_ex_flush(id_ex_fl), .o_ex_mem_flush(ex_mem_fl),
    .o_fault(fault), .o_state(state),
    .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  task automatic set_idle();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    rs1_used = 1'b0; rs2_used = 1'b0; ex_mem_read = 1'b0; redirect = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; mem_err = 1'b0;
    halt_clr = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic model_reset();
    m_state = 0; m_wait = 0; m_stall = 0; m_flush = 0;
  endtask

  // Compare registered outputs with the model.
  task automatic check_regs(input string tag);
    logic [1:0]    es;
    logic [CW-1:0] ec_s, ec_f;
    es   = m_state[1:0];
    ec_s = m_stall[CW-1:0];
    ec_f = m_flush[CW-1:0];
    n_checks++;
    if (state !== es) begin
      n_fail++; $display("FAIL %s state: got %b expected %b", tag, state, es);
    end
    n_checks++;
    if (fault !== (m_state == 2)) begin
      n_fail++; $display("FAIL %s fault: got %b expected %b", tag, fault, (m_state == 2));
    end
    n_checks++;
    if (stall_cnt !== ec_s) begin
      n_fail++; $display("FAIL %s stall_cnt: got %0d expected %0d", tag, stall_cnt, ec_s);
    end
    n_checks++;
    if (flush_cnt !== ec_f) begin
      n_fail++; $display("FAIL %s flush_cnt: got %0d expected %0d", tag, flush_cnt, ec_f);
    end
  endtask

  // One clock: entered at posedge+1 with inputs set; returns at next posedge+1.
  task automatic do_cycle(input string tag);
    logic [4:0] en;
    logic [2:0] fl;
    int         nxt;
    bit         lu, redir_taken, run_rules;
    #1;
    lu = ex_mem_read && (rd != 5'd0) &&
         ((rs1_used && rs1 == rd) || (rs2_used && rs2 == rd));
    en = 5'b00000; fl = 3'b000; nxt = m_state; redir_taken = 0; run_rules = 0;
    if (m_state == 0) begin
      if (mem_req && !mem_ready) nxt = 1;
      else begin
        run_rules = 1;
        nxt = (mem_req && mem_err) ? 2 : 0;
      end
    end else if (m_state == 1) begin
      if (mem_ready && !mem_err) begin run_rules = 1; nxt = 0; end
      else if (mem_ready) nxt = 2;
      else if (m_wait + 1 == T) nxt = 2;
      else nxt = 1;
    end else begin
      if (halt_clr) begin en = 5'b11111; fl = 3'b111; nxt = 0; end
      else nxt = 2;
    end
    if (run_rules) begin
      if (redirect) begin en = 5'b11111; fl = 3'b110; redir_taken = 1; end
      else if (lu) begin en = 5'b00111; fl = 3'b010; end
      else begin en = 5'b11111; fl = 3'b000; end
    end
    n_checks++;
    if ({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} !== en) begin
      n_fail++;
      $display("FAIL %s enables: got %b expected %b", tag,
               {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, en);
    end
    n_checks++;
    if ({if_id_fl, id_ex_fl, ex_mem_fl} !== fl) begin
      n_fail++;
      $display("FAIL %s flushes: got %b expected %b", tag, {if_id_fl, id_ex_fl, ex_mem_fl}, fl);
    end
    @(posedge clk);
    if (cnt_clr) begin m_stall = 0; m_flush = 0; end
    else begin
      if (!en[4] && m_stall < CMAX) m_stall++;
      if (redir_taken && m_flush < CMAX) m_flush++;
    end
    m_wait  = (m_state == 1 && nxt == 1) ? m_wait + 1 : 0;
    m_state = nxt;
    #1;
    check_regs(tag);
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if ({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} !== 5'b00000) begin
      n_fail++; $display("FAIL reset enables: got %b expected 00000",
                         {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en});
    end
    n_checks++;
    if ({if_id_fl, id_ex_fl, ex_mem_fl} !== 3'b111) begin
      n_fail++; $display("FAIL reset flushes: got %b expected 111", {if_id_fl, id_ex_fl, ex_mem_fl});
    end
    check_regs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_use();
    set_idle();
    ex_mem_read = 1'b1; rd = 5'd5; rs2 = 5'd5; rs2_used = 1'b1; rs1 = 5'd7; rs1_used = 1'b1;
    do_cycle("load_use_x5");
    set_idle();
    do_cycle("after_load_use");
    ex_mem_read = 1'b1; rd = 5'd0; rs1 = 5'd0; rs1_used = 1'b1;
    do_cycle("load_use_x0");
    set_idle();
  endtask

  task automatic test_redirect_beats_load_use();
    set_idle();
    ex_mem_read = 1'b1; rd = 5'd9; rs1 = 5'd9; rs1_used = 1'b1; redirect = 1'b1;
    do_cycle("redirect_vs_lu");
    set_idle();
  endtask

  task automatic test_three_wait();
    set_idle();
    cnt_clr = 1'b1;
    do_cycle("clr_before_wait");
    cnt_clr = 1'b0;
    mem_req = 1'b1; redirect = 1'b1;
    for (int i = 0; i < 3; i++) do_cycle($sformatf("wait_%0d", i));
    mem_ready = 1'b1;
    do_cycle("wait_exit_redirect");
    set_idle();
    do_cycle("post_wait");
  endtask

  task automatic test_timeout();
    set_idle();
    mem_req = 1'b1;
    for (int i = 0; i < T + 1; i++) do_cycle($sformatf("timeout_%0d", i));
    mem_ready = 1'b1;
    do_cycle("halt_ignores_ready");
    set_idle();
    halt_clr = 1'b1;
    do_cycle("halt_clr");
    halt_clr = 1'b0;
    do_cycle("after_halt_clr");
    halt_clr = 1'b1;
    do_cycle("halt_clr_in_run");
    set_idle();
  endtask

  task automatic test_bus_error();
    set_idle();
    mem_req = 1'b1; mem_ready = 1'b1; mem_err = 1'b1;
    do_cycle("bus_err_run");
    set_idle();
    halt_clr = 1'b1;
    do_cycle("bus_err_clr");
    set_idle();
    mem_req = 1'b1;
    do_cycle("bus_err_wait_entry");
    mem_ready = 1'b1; mem_err = 1'b1;
    do_cycle("bus_err_in_wait");
    set_idle(); halt_clr = 1'b1;
    do_cycle("bus_err_clr2");
    set_idle();
  endtask

  task automatic test_counters();
    set_idle();
    ex_mem_read = 1'b1; rd = 5'd3; rs1 = 5'd3; rs1_used = 1'b1;
    for (int i = 0; i < 20; i++) do_cycle("stall_sat");
    cnt_clr = 1'b1;
    do_cycle("clr_vs_inc");
    set_idle();
    redirect = 1'b1;
    for (int i = 0; i < 18; i++) do_cycle("flush_sat");
    set_idle();
  endtask

  task automatic test_reset_mid_wait();
    set_idle();
    ex_mem_read = 1'b1; rd = 5'd3; rs1 = 5'd3; rs1_used = 1'b1;
    do_cycle("pre_wait_stall");
    set_idle();
    mem_req = 1'b1;
    do_cycle("mid_wait_entry");
    do_cycle("mid_wait_1");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_regs("async_reset");
    n_checks++;
    if ({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_fl, id_ex_fl, ex_mem_fl} !== 8'b00000111) begin
      n_fail++; $display("FAIL async_reset comb: got %b expected 00000111",
        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_fl, id_ex_fl, ex_mem_fl});
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_idle();
    @(posedge clk);
    #1;
    do_cycle("after_async_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
      rd  = 5'($urandom_range(0, 3));
      rs1_used = 1'($urandom_range(0, 1)); rs2_used = 1'($urandom_range(0, 1));
      ex_mem_read = 1'($urandom_range(0, 1));
      redirect  = ($urandom_range(0, 3) == 0);
      mem_req   = ($urandom_range(0, 2) == 0);
      mem_ready = ($urandom_range(0, 2) == 0);
      mem_err   = ($urandom_range(0, 9) == 0);
      halt_clr  = ($urandom_range(0, 3) == 0);
      cnt_clr   = ($urandom_range(0, 29) == 0);
      do_cycle("random");
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect_beats_load_use();
    test_three_wait();
    test_timeout();
    test_bus_error();
    test_counters();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
